// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM encodings and default width for the bit-serial adder
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - full adder composed of two half-adder cells and an OR of their carries
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a    (a),
    .b    (b),
    .sum  (s1),
    .cout (c1)
  );

  half_adder u_ha1 (
    .a    (s1),
    .b    (cin),
    .sum  (sum),
    .cout (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder: one sum bit per SHIFT cycle, result registered on the last
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        // Shift-and-OR keeps the MSB insertion legal when WIDTH is 1.
        res_d   = (res_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = res_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic reference model
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Stimulus only: issues one start, scrambles inputs afterwards, and records what it observes.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        output int done_k, output int busy_cnt, output int done_cnt,
                        output logic [W-1:0] got_sum, output logic got_cout);
    done_k = 0; busy_cnt = 0; done_cnt = 0; got_sum = '0; got_cout = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k == 0) begin
          done_k = k; got_sum = sum; got_cout = cout;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[4]   = '{8'h3C, 8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] tb_[4]  = '{8'h5A, 8'h01, 8'hFF, 8'h00};
    logic         tc[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] es[4]   = '{8'h96, 8'h00, 8'hFF, 8'h00};
    logic         ec[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    int dk, bc, dc;
    logic [W-1:0] gs;
    logic gc;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb_[i], tc[i], dk, bc, dc, gs, gc);
      checks++; if (gs !== es[i]) begin failures++; $display("FAIL directed_sum[%0d] got=%h exp=%h", i, gs, es[i]); end
      checks++; if (gc !== ec[i]) begin failures++; $display("FAIL directed_cout[%0d] got=%b exp=%b", i, gc, ec[i]); end
      checks++; if (dk != W + 1) begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, dk, W + 1); end
      checks++; if (bc != W) begin failures++; $display("FAIL directed_busy_cycles[%0d] got=%0d exp=%0d", i, bc, W); end
      checks++; if (dc != 1) begin failures++; $display("FAIL directed_done_pulses[%0d] got=%0d exp=1", i, dc); end
    end
  endtask

  task automatic test_start_ignored;
    int dc = 0;
    int bc = 0;
    logic [W-1:0] gs = '0;
    logic gc = 1'b0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin a = 8'h01; b = 8'h01; end
      if (done === 1'b1) begin dc++; gs = sum; gc = cout; end
    end
    start = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (done === 1'b1) dc++;
    end
    checks++; if (gs !== 8'h30) begin failures++; $display("FAIL ignored_sum got=%h exp=30", gs); end
    checks++; if (gc !== 1'b0) begin failures++; $display("FAIL ignored_cout got=%b exp=0", gc); end
    checks++; if (dc != 1) begin failures++; $display("FAIL ignored_done_pulses got=%0d exp=1", dc); end
    checks++; if (bc != 0) begin failures++; $display("FAIL ignored_restart_busy got=%0d exp=0", bc); end
  endtask

  task automatic test_mid_reset;
    int dk, bc, dc;
    logic [W-1:0] gs;
    logic gc;
    run_op(8'h11, 8'h22, 1'b0, dk, bc, dc, gs, gc);
    checks++; if (gs !== 8'h33) begin failures++; $display("FAIL pre_reset_sum got=%h exp=33", gs); end
    @(negedge clk);
    a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL midreset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midreset_cout got=%b exp=0", cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    checks++; if (dc != 0) begin failures++; $display("FAIL midreset_done_pulses got=%0d exp=0", dc); end
    run_op(8'h07, 8'h08, 1'b0, dk, bc, dc, gs, gc);
    checks++; if (gs !== 8'h0F) begin failures++; $display("FAIL post_reset_sum got=%h exp=0f", gs); end
    checks++; if (gc !== 1'b0) begin failures++; $display("FAIL post_reset_cout got=%b exp=0", gc); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    int           ops = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    logic [W:0]   e;
    int           stable_bad = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < 50; n++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      qa.push_back(a); qb.push_back(b); qc.push_back(cin);
      @(negedge clk);
      if (done === 1'b1) begin
        // Operation m is sampled at edge 10*m and reports done in the cycle after edge 10*m+8.
        e = model_add(qa[10 * ops], qb[10 * ops], qc[10 * ops]);
        checks++; if (n + 1 != 10 * ops + W + 1) begin failures++; $display("FAIL b2b_done_cycle[%0d] got=%0d exp=%0d", ops, n + 1, 10 * ops + W + 1); end
        checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL b2b_result[%0d] got=%b_%h exp=%b_%h", ops, cout, sum, e[W], e[W-1:0]); end
        last_sum = sum; last_cout = cout;
        ops++;
      end else if (ops > 0) begin
        if (sum !== last_sum || cout !== last_cout) stable_bad++;
      end
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    checks++; if (ops != 5) begin failures++; $display("FAIL b2b_op_count got=%0d exp=5", ops); end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL b2b_result_stability got=%0d exp=0", stable_bad); end
  endtask

  task automatic test_random;
    int dk, bc, dc;
    logic [W-1:0] gs;
    logic gc;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W:0] e;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      e = model_add(ra, rb, rc);
      run_op(ra, rb, rc, dk, bc, dc, gs, gc);
      checks++; if ({gc, gs} !== e) begin failures++; $display("FAIL random_result[%0d] a=%h b=%h cin=%b got=%b_%h exp=%b_%h", i, ra, rb, rc, gc, gs, e[W], e[W-1:0]); end
      checks++; if (dk != W + 1 || dc != 1 || bc != W) begin failures++; $display("FAIL random_timing[%0d] done_at=%0d pulses=%0d busy=%0d exp=%0d/1/%0d", i, dk, dc, bc, W + 1, W); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
